// File: rtl/msi_bus_ctrl.sv
// ---------------------------------------------------------------------------
// msi_bus_ctrl -- two-core MSI snooping bus controller.
//
// Arbitrates coherence requests from two cores, snoops the other core for
// the requested word, falls back to a memory read when the snoop misses,
// returns the fill word on the bus and pulses done to the requester.
//
// Ports
//   clk, rst_n                      clock / asynchronous active-low reset
//   read_miss, write_miss,
//   invalidate [1:0]                per-core requests (bit i = core i)
//   req_addr0, req_addr1 [10:0]     per-core request word address
//   grant [1:0]                     one-hot bus ownership (SNOOP..DONE)
//   done [1:0]                      one-cycle completion pulse
//   boci [10:0], cpu_search [1:0]   snoop address and strobe
//   search_found [1:0],
//   other_data0/1 [15:0]            snoop responses (valid in SNOOP cycle)
//   snoop_inval [1:0]               invalidate strobe to the other core
//   bus_data [15:0], bus_valid      fill word and its qualifier (XFER)
//   mem_re, mem_addr [10:0],
//   mem_rdy, mem_rdata [15:0]       memory read port
//   bus_err                         memory timeout pulse
//
// Build option
//   MEM_TIMEOUT_EN  when defined, MEMRD gives up after 255 cycles without
//                   mem_rdy, pulses bus_err and returns a zero word.
//                   When undefined, MEMRD waits forever and bus_err is 0.
// ---------------------------------------------------------------------------
module msi_bus_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  read_miss,
  input  logic [1:0]  write_miss,
  input  logic [1:0]  invalidate,
  input  logic [10:0] req_addr0,
  input  logic [10:0] req_addr1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [10:0] boci,
  output logic [1:0]  cpu_search,
  input  logic [1:0]  search_found,
  input  logic [15:0] other_data0,
  input  logic [15:0] other_data1,
  output logic [1:0]  snoop_inval,
  output logic [15:0] bus_data,
  output logic        bus_valid,
  output logic        mem_re,
  output logic [10:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [15:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {IDLE, SNOOP, MEMRD, XFER, DONE} state_t;
  typedef enum logic [1:0] {T_READ, T_WRITE, T_INVAL} req_t;

  state_t      state_reg;
  logic        ptr_reg;
  logic        winner_reg;
  logic        contend_reg;
  req_t        type_reg;
  logic [10:0] addr_reg;

  logic [1:0]  grant_reg;
  logic [1:0]  done_reg;
  logic [10:0] boci_reg;
  logic [1:0]  cpu_search_reg;
  logic [1:0]  snoop_inval_reg;
  logic [15:0] bus_data_reg;
  logic        bus_valid_reg;
  logic        mem_re_reg;
  logic [10:0] mem_addr_reg;

  // Arbitration and snoop-response selection.
  logic [1:0]  req_vec;
  logic        win_sel;
  logic [10:0] addr_sel;
  req_t        type_sel;
  logic        other;
  logic        found_other;
  logic [15:0] other_word;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    req_vec  = read_miss | write_miss | invalidate;
    // Round-robin pointer only matters when both cores are asking.
    win_sel  = (req_vec == 2'b11) ? ptr_reg : req_vec[1];
    addr_sel = win_sel ? req_addr1 : req_addr0;
    if (invalidate[win_sel])      type_sel = T_INVAL;
    else if (write_miss[win_sel]) type_sel = T_WRITE;
    else                          type_sel = T_READ;
    other       = ~winner_reg;
    found_other = search_found[other];
    other_word  = other ? other_data1 : other_data0;
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_reg;
  logic       bus_err_reg;
  assign bus_err = bus_err_reg;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= 1'b0;
      winner_reg      <= 1'b0;
      contend_reg     <= 1'b0;
      type_reg        <= T_READ;
      addr_reg        <= '0;
      grant_reg       <= '0;
      done_reg        <= '0;
      boci_reg        <= '0;
      cpu_search_reg  <= '0;
      snoop_inval_reg <= '0;
      bus_data_reg    <= '0;
      bus_valid_reg   <= 1'b0;
      mem_re_reg      <= 1'b0;
      mem_addr_reg    <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      bus_err_reg     <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes fall back to zero unless a state re-asserts them.
      done_reg        <= '0;
      boci_reg        <= '0;
      cpu_search_reg  <= '0;
      snoop_inval_reg <= '0;
      bus_data_reg    <= '0;
      bus_valid_reg   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_reg     <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (req_vec != 2'b00) begin
            state_reg      <= SNOOP;
            winner_reg     <= win_sel;
            type_reg       <= type_sel;
            addr_reg       <= addr_sel;
            contend_reg    <= (req_vec == 2'b11);
            grant_reg      <= onehot(win_sel);
            boci_reg       <= addr_sel;
            cpu_search_reg <= onehot(~win_sel);
          end
        end
        SNOOP: begin
          if (type_reg == T_INVAL) begin
            state_reg       <= XFER;
            snoop_inval_reg <= onehot(other);
          end else if (found_other) begin
            state_reg       <= XFER;
            bus_valid_reg   <= 1'b1;
            bus_data_reg    <= other_word;
            snoop_inval_reg <= (type_reg == T_WRITE) ? onehot(other) : 2'b00;
          end else begin
            state_reg    <= MEMRD;
            mem_re_reg   <= 1'b1;
            mem_addr_reg <= addr_reg;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_reg  <= '0;
`endif
          end
        end
        MEMRD: begin
          if (mem_rdy) begin
            state_reg       <= XFER;
            mem_re_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            bus_valid_reg   <= 1'b1;
            bus_data_reg    <= mem_rdata;
            snoop_inval_reg <= (type_reg == T_WRITE) ? onehot(other) : 2'b00;
          end
`ifdef MEM_TIMEOUT_EN
          // 255th MEMRD cycle without mem_rdy: give up with a zero word.
          else if (tmo_cnt_reg == 8'd254) begin
            state_reg       <= XFER;
            mem_re_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            bus_valid_reg   <= 1'b1;
            bus_data_reg    <= 16'h0000;
            bus_err_reg     <= 1'b1;
            snoop_inval_reg <= (type_reg == T_WRITE) ? onehot(other) : 2'b00;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
`endif
        end
        XFER: begin
          state_reg <= DONE;
          done_reg  <= onehot(winner_reg);
          // Hand priority to the loser only if there actually was one.
          if (contend_reg) ptr_reg <= ~winner_reg;
        end
        DONE: begin
          state_reg <= IDLE;
          grant_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant       = grant_reg;
  assign done        = done_reg;
  assign boci        = boci_reg;
  assign cpu_search  = cpu_search_reg;
  assign snoop_inval = snoop_inval_reg;
  assign bus_data    = bus_data_reg;
  assign bus_valid   = bus_valid_reg;
  assign mem_re      = mem_re_reg;
  assign mem_addr    = mem_addr_reg;

endmodule

// File: tb/tb_msi_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msi_bus_ctrl -- scoreboard bench for msi_bus_ctrl (default build).
// Stimulus pushes the expected bus events (snoop, memory start, transfer,
// done) with their cycle numbers; a monitor pops and compares whenever the
// DUT shows one of those events.
// ---------------------------------------------------------------------------
module tb_msi_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  read_miss, write_miss, invalidate;
  logic [10:0] req_addr0, req_addr1;
  logic [1:0]  grant, done;
  logic [10:0] boci;
  logic [1:0]  cpu_search;
  logic [1:0]  search_found;
  logic [15:0] other_data0, other_data1;
  logic [1:0]  snoop_inval;
  logic [15:0] bus_data;
  logic        bus_valid;
  logic        mem_re;
  logic [10:0] mem_addr;
  logic        mem_rdy;
  logic [15:0] mem_rdata;
  logic        bus_err;

  msi_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .grant(grant), .done(done), .boci(boci), .cpu_search(cpu_search),
    .search_found(search_found), .other_data0(other_data0), .other_data1(other_data1),
    .snoop_inval(snoop_inval), .bus_data(bus_data), .bus_valid(bus_valid),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  localparam int K_SNP = 0, K_MEM = 1, K_XFR = 2, K_DONE = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [47:0] val;
    string       name;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Environment knobs driven by the stimulus.
  logic [1:0]  found_cfg = 2'b00;
  int          mem_wait = 0;
  logic [15:0] mem_data_cfg = 16'h0000;
  logic        spurious_rdy = 1'b0;
  int          mem_cnt = 0;
  logic        mem_re_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Snoop responder: only the strobed core can answer.
  assign search_found = cpu_search & found_cfg;

  // Memory model: answers mem_wait cycles after mem_re rises; outside a
  // read it may assert a stray mem_rdy that the DUT must ignore.
  always @(negedge clk) begin
    if (mem_re) begin
      if (mem_cnt == mem_wait) begin
        mem_rdy   = 1'b1;
        mem_rdata = mem_data_cfg;
      end else begin
        mem_rdy   = 1'b0;
        mem_rdata = 16'hDEAD;
        mem_cnt++;
      end
    end else begin
      mem_cnt   = 0;
      mem_rdy   = spurious_rdy;
      mem_rdata = 16'hDEAD;
    end
  end

  function automatic logic [47:0] v_snp(input logic [1:0] g, input logic [1:0] cs, input logic [10:0] a);
    return {33'd0, g, cs, a};
  endfunction
  function automatic logic [47:0] v_mem(input logic [1:0] g, input logic [10:0] a);
    return {35'd0, g, a};
  endfunction
  function automatic logic [47:0] v_xfr(input logic [1:0] g, input logic bv, input logic [1:0] si,
                                        input logic [15:0] d, input logic err);
    return {26'd0, g, bv, si, d, err};
  endfunction
  function automatic logic [47:0] v_done(input logic [1:0] g, input logic [1:0] d);
    return {44'd0, g, d};
  endfunction

  task automatic expect_evt(input int kind, input string name, input int at, input logic [47:0] v);
    evt_t e;
    e.kind = kind;
    e.cyc  = at;
    e.val  = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int kind, input logic [47:0] v);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cycle=%0d got=%h required=none", kind, cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != v) begin
        errors++;
        $display("FAIL %s got kind=%0d cycle=%0d val=%h required kind=%0d cycle=%0d val=%h",
                 e.name, kind, cyc, v, e.kind, e.cyc, e.val);
      end else if (kind == K_DONE) begin
        $display("txn %s ok at cycle %0d", e.name, cyc);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Monitor: every visible bus event is matched against the scoreboard.
  always @(negedge clk) begin
    if (cpu_search != 2'b00)
      check_evt(K_SNP, v_snp(grant, cpu_search, boci));
    if (mem_re && !mem_re_prev)
      check_evt(K_MEM, v_mem(grant, mem_addr));
    if (bus_valid || snoop_inval != 2'b00 || bus_err)
      check_evt(K_XFR, v_xfr(grant, bus_valid, snoop_inval, bus_data, bus_err));
    if (done != 2'b00)
      check_evt(K_DONE, v_done(grant, done));
    mem_re_prev = mem_re;
  end

  // kind: 0 read_miss, 1 write_miss, 2 invalidate
  task automatic start_req(input int core, input int kind, input logic [10:0] addr);
    if (core == 0) req_addr0 = addr; else req_addr1 = addr;
    case (kind)
      0:       read_miss[core]  = 1'b1;
      1:       write_miss[core] = 1'b1;
      default: invalidate[core] = 1'b1;
    endcase
  endtask

  // Requesters hold until their done pulse; bounded wait.
  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((read_miss | write_miss | invalidate) != 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 2; i++) begin
        if (done[i]) begin
          read_miss[i]  = 1'b0;
          write_miss[i] = 1'b0;
          invalidate[i] = 1'b0;
        end
      end
    end
    if ((read_miss | write_miss | invalidate) != 2'b00) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending=%b after %0d cycles required=00",
               read_miss | write_miss | invalidate, n);
      read_miss = '0; write_miss = '0; invalidate = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r;
    read_miss = '0; write_miss = '0; invalidate = '0;
    req_addr0 = '0; req_addr1 = '0;
    other_data0 = '0; other_data1 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_bus_valid", 32'(bus_valid), 32'h0);
    chk("reset_mem_re", 32'(mem_re), 32'h0);
    chk("reset_bus_err", 32'(bus_err), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Read miss hit in core1, with a stray mem_rdy outside MEMRD.
    @(negedge clk); c0 = cyc;
    spurious_rdy = 1'b1; found_cfg = 2'b10; other_data1 = 16'hBEEF;
    start_req(0, 0, 11'h045);
    expect_evt(K_SNP,  "rd_hit_snoop", c0 + 1, v_snp(2'b01, 2'b10, 11'h045));
    expect_evt(K_XFR,  "rd_hit_xfer",  c0 + 2, v_xfr(2'b01, 1'b1, 2'b00, 16'hBEEF, 1'b0));
    expect_evt(K_DONE, "rd_hit_core0", c0 + 3, v_done(2'b01, 2'b01));
    run_until_idle(40);
    spurious_rdy = 1'b0;

    // Write miss from core1 served by memory after 4 wait cycles.
    @(negedge clk); c0 = cyc;
    found_cfg = 2'b00; mem_wait = 4; mem_data_cfg = 16'h1234;
    start_req(1, 1, 11'h100);
    expect_evt(K_SNP,  "wr_mem_snoop", c0 + 1, v_snp(2'b10, 2'b01, 11'h100));
    expect_evt(K_MEM,  "wr_mem_read",  c0 + 2, v_mem(2'b10, 11'h100));
    expect_evt(K_XFR,  "wr_mem_xfer",  c0 + 7, v_xfr(2'b10, 1'b1, 2'b01, 16'h1234, 1'b0));
    expect_evt(K_DONE, "wr_mem_core1", c0 + 8, v_done(2'b10, 2'b10));
    run_until_idle(40);

    // Invalidate (with a concurrent read_miss) to the top address; snoop
    // hit must be ignored.
    @(negedge clk); c0 = cyc;
    found_cfg = 2'b10; other_data1 = 16'h5555;
    start_req(0, 2, 11'h7FF);
    read_miss[0] = 1'b1;
    expect_evt(K_SNP,  "inval_snoop", c0 + 1, v_snp(2'b01, 2'b10, 11'h7FF));
    expect_evt(K_XFR,  "inval_xfer",  c0 + 2, v_xfr(2'b01, 1'b0, 2'b10, 16'h0000, 1'b0));
    expect_evt(K_DONE, "inval_core0", c0 + 3, v_done(2'b01, 2'b01));
    run_until_idle(40);

    // Simultaneous requests after reset pointer: core0 then core1.
    @(negedge clk); c0 = cyc;
    found_cfg = 2'b11; other_data0 = 16'hAAAA; other_data1 = 16'hBBBB;
    start_req(0, 0, 11'h011);
    start_req(1, 0, 11'h022);
    expect_evt(K_SNP,  "rr1_c0_snoop", c0 + 1, v_snp(2'b01, 2'b10, 11'h011));
    expect_evt(K_XFR,  "rr1_c0_xfer",  c0 + 2, v_xfr(2'b01, 1'b1, 2'b00, 16'hBBBB, 1'b0));
    expect_evt(K_DONE, "rr1_core0",    c0 + 3, v_done(2'b01, 2'b01));
    expect_evt(K_SNP,  "rr1_c1_snoop", c0 + 5, v_snp(2'b10, 2'b01, 11'h022));
    expect_evt(K_XFR,  "rr1_c1_xfer",  c0 + 6, v_xfr(2'b10, 1'b1, 2'b00, 16'hAAAA, 1'b0));
    expect_evt(K_DONE, "rr1_core1",    c0 + 7, v_done(2'b10, 2'b10));
    run_until_idle(40);

    // Repeat: pointer now favours core1.
    @(negedge clk); c0 = cyc;
    start_req(0, 0, 11'h044);
    start_req(1, 1, 11'h033);
    expect_evt(K_SNP,  "rr2_c1_snoop", c0 + 1, v_snp(2'b10, 2'b01, 11'h033));
    expect_evt(K_XFR,  "rr2_c1_xfer",  c0 + 2, v_xfr(2'b10, 1'b1, 2'b01, 16'hAAAA, 1'b0));
    expect_evt(K_DONE, "rr2_core1",    c0 + 3, v_done(2'b10, 2'b10));
    expect_evt(K_SNP,  "rr2_c0_snoop", c0 + 5, v_snp(2'b01, 2'b10, 11'h044));
    expect_evt(K_XFR,  "rr2_c0_xfer",  c0 + 6, v_xfr(2'b01, 1'b1, 2'b00, 16'hBBBB, 1'b0));
    expect_evt(K_DONE, "rr2_core0",    c0 + 7, v_done(2'b01, 2'b01));
    run_until_idle(40);

    // Reset in the middle of MEMRD, then the held request is re-served.
    @(negedge clk); c0 = cyc;
    found_cfg = 2'b00; mem_wait = 100; mem_data_cfg = 16'h4321;
    start_req(0, 0, 11'h0AB);
    expect_evt(K_SNP, "rst_pre_snoop", c0 + 1, v_snp(2'b01, 2'b10, 11'h0AB));
    expect_evt(K_MEM, "rst_pre_mem",   c0 + 2, v_mem(2'b01, 11'h0AB));
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'h0);
    chk("async_rst_mem_re", 32'(mem_re), 32'h0);
    chk("async_rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("async_rst_boci", 32'(boci), 32'h0);
    chk("async_rst_bus_valid", 32'(bus_valid), 32'h0);
    @(negedge clk); r = cyc;
    mem_wait = 0;
    rst_n = 1'b1;
    expect_evt(K_SNP,  "rst_post_snoop", r + 1, v_snp(2'b01, 2'b10, 11'h0AB));
    expect_evt(K_MEM,  "rst_post_mem",   r + 2, v_mem(2'b01, 11'h0AB));
    expect_evt(K_XFR,  "rst_post_xfer",  r + 3, v_xfr(2'b01, 1'b1, 2'b00, 16'h4321, 1'b0));
    expect_evt(K_DONE, "rst_post_core0", r + 4, v_done(2'b01, 2'b01));
    run_until_idle(40);

    repeat (4) @(negedge clk);
    chk("idle_grant", 32'(grant), 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msi_bus_ctrl.md
MSI_BUS_CTRL -- requirements
Module: msi_bus_ctrl

Interface
REQ-001 SHALL: clk  input  1  clock, all state on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: read_miss[1:0], write_miss[1:0], invalidate[1:0]  input  2 each  per-core coherence requests, bit i = core i.
REQ-004 SHALL: req_addr0, req_addr1  input  11 each  requesting word address (BOCI format) per core.
REQ-005 SHALL: grant[1:0]  output  2  one-hot bus ownership.
REQ-006 SHALL: done[1:0]  output  2  one-cycle completion pulse to the requester.
REQ-007 SHALL: boci  output  11  broadcast snoop address; cpu_search[1:0]  output  2  snoop strobe per core.
REQ-008 SHALL: search_found[1:0]  input  2 and other_data0, other_data1  input  16 each  snoop responses, valid combinationally in the cpu_search cycle.
REQ-009 SHALL: snoop_inval[1:0]  output  2  one-cycle invalidate strobe to the non-requesting core.
REQ-010 SHALL: bus_data  output  16  fill data; bus_valid  output  1  bus_data qualifier.
REQ-011 SHALL: mem_re  output  1, mem_addr  output  11, mem_rdy  input  1, mem_rdata  input  16  memory read port.
REQ-012 SHALL: bus_err  output  1  timeout error pulse (present only with MEM_TIMEOUT_EN).

Function
REQ-013 SHALL: FSM states IDLE, SNOOP, MEMRD, XFER, DONE.
REQ-014 SHALL: core i requests when any of read_miss[i]/write_miss[i]/invalidate[i] is high; requesters hold the request until done[i].
REQ-015 SHALL: IDLE with >=1 requester -> SNOOP next cycle, latching winner, type and address; priority within a core invalidate > write_miss > read_miss.
REQ-016 SHALL: simultaneous requests resolved round-robin by 1-bit pointer (reset 0 = core 0 first); pointer moves to the loser on entering DONE.
REQ-017 SHALL: grant[winner] high from SNOOP through DONE inclusive, zero in IDLE.
REQ-018 SHALL: SNOOP lasts one cycle: boci = latched address, cpu_search[other]=1; search_found[other] and other_dataN sampled at its end.
REQ-019 SHALL: invalidate -> XFER with snoop_inval[other]=1, no data.
REQ-020 SHALL: read/write miss with found -> XFER, bus_data = captured other-core word.
REQ-021 SHALL: read/write miss not found -> MEMRD: mem_re=1, mem_addr=latched address until mem_rdy; capture mem_rdata on mem_rdy, then XFER.
REQ-022 SHALL: XFER one cycle: bus_valid=1 for misses; write_miss additionally pulses snoop_inval[other].
REQ-023 SHALL: DONE one cycle: done[winner]=1 -> IDLE; new requests not sampled until IDLE.
REQ-024 SHALL: minimum latency request-to-done = 3 cycles (snoop hit or invalidate); memory path = 3 + mem_rdy wait + 1.
REQ-025 SHALL: mem_rdy asserted outside MEMRD is ignored.

Reset
REQ-026 SHALL: rst_n low at any time, including mid-transaction, forces IDLE, pointer 0, all outputs 0, latched data 0; aborted transaction is not completed.

Configuration
REQ-027 SHALL: macro MEM_TIMEOUT_EN defined -> 8-bit counter in MEMRD; at 255 cycles without mem_rdy: bus_err pulse 1 cycle, bus_data=16'h0000, proceed XFER/DONE normally.
REQ-028 SHALL: MEM_TIMEOUT_EN undefined -> no counter, MEMRD waits indefinitely, bus_err tied 0.

Verification
REQ-029 SHALL: core0 read_miss addr 11'h045, core1 found, other_data1=16'hBEEF -> bus_data=BEEF, bus_valid at cycle 2, done[0] cycle 3, no mem_re.
REQ-030 SHALL: core1 write_miss addr 11'h100, core0 not found, mem_rdy after 4 cycles with 16'h1234 -> bus_data=1234, snoop_inval[0] with bus_valid, done[1].
REQ-031 SHALL: both cores request same cycle after reset -> core0 served first, core1 next; repeat -> core1 first.
REQ-032 SHALL: core0 invalidate addr 11'h7FF -> snoop_inval[1] one cycle, bus_valid stays 0, done[0] at cycle 3.
REQ-033 SHALL: rst_n low during MEMRD -> all outputs 0 asynchronously, IDLE after release, pending request re-served from scratch.
REQ-034 SHALL: MEM_TIMEOUT_EN, mem_rdy never high -> bus_err after 255 MEMRD cycles, bus_data=0000, done issued.
